// File: rtl/instr_encode_loader.sv
// Boot/test loader encoder: packs R/I/L/S instruction fields into 16-bit words and
// streams the legal ones into instruction memory from a programmable base address.
//
// state  | meaning
// IDLE   | after reset, waiting for start_i
// ACCEPT | session open, in_ready_o high, fields checked on handshake
// WRITE  | encoded word presented to memory until imem_ready_i
// FULL   | DEPTH words written, waiting for start_i
module instr_encode_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        op_i,
   input  logic [2:0]        rd_i,
   input  logic [2:0]        rs1_i,
   input  logic [2:0]        rs2_i,
   input  logic [3:0]        func4_i,
   input  logic [1:0]        func2_i,
   input  logic [5:0]        imm_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [15:0]       imem_wdata_o,
   input  logic              imem_ready_i,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              err_o,
   output logic [1:0]        err_code_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCEPT = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_FULL   = 2'd3;

   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic [15:0]       r_wdata;
   logic              r_err;
   logic [1:0]        r_err_code;

   logic [15:0]       w_enc;
   logic [1:0]        w_err_code;
   logic              w_start;
   logic              w_accept;
   logic              w_commit;
   logic [ADDR_W:0]   w_count_inc;

   // Unused fields of each format are zero; bit 3 is always zero.
   always_comb begin
      w_enc = 16'h0000;
      case (op_i)
         3'b000:  w_enc = {func4_i, rs2_i[1:0], rd_i, rs1_i, 1'b0, op_i};
         3'b001:  w_enc = {imm_i, rd_i, rs1_i, 1'b0, op_i};
         3'b010:  w_enc = {imm_i[3:0], func2_i, rd_i, rs1_i, 1'b0, op_i};
         3'b011:  w_enc = {imm_i[3:0], func2_i, rs2_i, rs1_i, 1'b0, op_i};
         default: w_enc = 16'h0000;
      endcase
   end

   // R-type func4[0] and rs2[2] share word bit 12, so they must agree.
   always_comb begin
      w_err_code = 2'b00;
      if (op_i[2])
         w_err_code = 2'b01;
      else if (op_i == 3'b000 && func4_i[0] != rs2_i[2])
         w_err_code = 2'b10;
      else if (op_i[1] && imm_i[5:4] != 2'b00)
         w_err_code = 2'b11;
   end

   assign w_start     = start_i && (r_state != S_WRITE);
   assign w_accept    = (r_state == S_ACCEPT) && in_valid_i && !start_i;
   assign w_commit    = (r_state == S_WRITE) && imem_ready_i;
   assign w_count_inc = r_count + (ADDR_W+1)'(1);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_start) w_state_nxt = S_ACCEPT;
         S_ACCEPT: begin
            if (w_start)
               w_state_nxt = S_ACCEPT;
            else if (w_accept && w_err_code == 2'b00)
               w_state_nxt = S_WRITE;
         end
         S_WRITE:  if (w_commit) w_state_nxt = (w_count_inc == C_DEPTH) ? S_FULL : S_ACCEPT;
         S_FULL:   if (w_start) w_state_nxt = S_ACCEPT;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= '0;
         r_count    <= '0;
         r_wdata    <= 16'h0000;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
      end else begin
         r_err <= 1'b0;
         if (w_start) begin
            r_addr     <= base_addr_i;
            r_count    <= '0;
            r_err_code <= 2'b00;
         end else if (w_accept) begin
            if (w_err_code == 2'b00) begin
               r_wdata <= w_enc;
            end else begin
               r_err      <= 1'b1;
               r_err_code <= w_err_code;
            end
         end else if (w_commit) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= w_count_inc;
         end
      end
   end

   always_comb begin
      in_ready_o = 1'b0;
      imem_we_o  = 1'b0;
      full_o     = 1'b0;
      case (r_state)
         S_ACCEPT: in_ready_o = 1'b1;
         S_WRITE:  imem_we_o  = 1'b1;
         S_FULL:   full_o     = 1'b1;
         default:  ;
      endcase
   end

   assign imem_addr_o  = r_addr;
   assign imem_wdata_o = r_wdata;
   assign count_o      = r_count;
   assign err_o        = r_err;
   assign err_code_o   = r_err_code;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: directed scenarios plus randomized fields checked
// against an arithmetic model of the instruction formats and legality rules.
module tb_instr_encode_loader;

   logic       clk = 1'b0;
   logic       rst, start_i, in_valid_i, imem_ready_i;
   logic [7:0] base_addr_i;
   logic [2:0] op_i, rd_i, rs1_i, rs2_i;
   logic [3:0] func4_i;
   logic [1:0] func2_i;
   logic [5:0] imm_i;

   logic        in_ready_o, imem_we_o, full_o, err_o;
   logic [7:0]  imem_addr_o;
   logic [15:0] imem_wdata_o;
   logic [8:0]  count_o;
   logic [1:0]  err_code_o;

   logic        in_ready4, we4, full4, err4;
   logic [7:0]  addr4;
   logic [15:0] wdata4;
   logic [8:0]  count4;
   logic [1:0]  code4;

   int n_checks = 0;
   int n_fail   = 0;
   int m_addr;
   int m_count;

   always #5 clk = ~clk;

   instr_encode_loader #(.ADDR_W(8), .DEPTH(256)) u_dut (
      .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i), .rd_i(rd_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .func4_i(func4_i), .func2_i(func2_i), .imm_i(imm_i),
      .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
      .imem_ready_i(imem_ready_i), .count_o(count_o), .full_o(full_o),
      .err_o(err_o), .err_code_o(err_code_o));

   instr_encode_loader #(.ADDR_W(8), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready4), .op_i(op_i), .rd_i(rd_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .func4_i(func4_i), .func2_i(func2_i), .imm_i(imm_i),
      .imem_we_o(we4), .imem_addr_o(addr4), .imem_wdata_o(wdata4),
      .imem_ready_i(imem_ready_i), .count_o(count4), .full_o(full4),
      .err_o(err4), .err_code_o(code4));

   function automatic logic [15:0] model_word(int op, int rd, int rs1, int rs2,
                                              int f4, int f2, int imm);
      int w;
      case (op)
         0:       w = f4 * 4096 + (rs2 % 4) * 1024 + rd * 128 + rs1 * 16;
         1:       w = imm * 1024 + rd * 128 + rs1 * 16;
         2:       w = (imm % 16) * 4096 + f2 * 1024 + rd * 128 + rs1 * 16;
         3:       w = (imm % 16) * 4096 + f2 * 1024 + rs2 * 128 + rs1 * 16;
         default: w = 0;
      endcase
      w = w + op;
      return w[15:0];
   endfunction

   function automatic int model_err(int op, int rs2, int f4, int imm);
      if (op >= 4) return 1;
      if (op == 0 && (f4 % 2) != (rs2 / 4)) return 2;
      if ((op == 2 || op == 3) && imm >= 16) return 3;
      return 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; imem_ready_i = 1'b0;
      base_addr_i = 8'h00;
      op_i = 3'd0; rd_i = 3'd0; rs1_i = 3'd0; rs2_i = 3'd0;
      func4_i = 4'd0; func2_i = 2'd0; imm_i = 6'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start(input logic [7:0] b);
      start_i = 1'b1;
      base_addr_i = b;
      tick();
      start_i = 1'b0;
      m_addr = int'(b);
      m_count = 0;
   endtask

   task automatic set_fields(input int op, input int rd, input int rs1, input int rs2,
                             input int f4, input int f2, input int imm);
      op_i = op[2:0]; rd_i = rd[2:0]; rs1_i = rs1[2:0]; rs2_i = rs2[2:0];
      func4_i = f4[3:0]; func2_i = f2[1:0]; imm_i = imm[5:0];
   endtask

   task automatic issue();
      in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
   endtask

   task automatic commit(input int delay);
      repeat (delay) tick();
      imem_ready_i = 1'b1;
      tick();
      imem_ready_i = 1'b0;
      m_addr = (m_addr + 1) % 256;
      m_count = m_count + 1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, count_o, full_o, err_o, err_code_o}
          !== {1'b0, 1'b0, 8'h00, 16'h0000, 9'd0, 1'b0, 1'b0, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_values rdy=%0b we=%0b addr=%h wdata=%h cnt=%0d full=%0b err=%0b code=%0d exp all zero",
                  in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, count_o, full_o, err_o, err_code_o);
      end
   endtask

   task automatic test_directed_r();
      do_start(8'h10);
      n_checks++;
      if ({in_ready_o, imem_addr_o, count_o} !== {1'b1, 8'h10, 9'd0}) begin
         n_fail++;
         $display("FAIL start_state rdy=%0b addr=%h cnt=%0d exp rdy=1 addr=10 cnt=0",
                  in_ready_o, imem_addr_o, count_o);
      end
      set_fields(0, 5, 3, 6, 5, 0, 0);
      issue();
      n_checks++;
      if ({imem_we_o, in_ready_o, imem_addr_o, imem_wdata_o} !== {1'b1, 1'b0, 8'h10, 16'h5AB0}) begin
         n_fail++;
         $display("FAIL r_write we=%0b rdy=%0b addr=%h wdata=%h exp we=1 rdy=0 addr=10 wdata=5ab0",
                  imem_we_o, in_ready_o, imem_addr_o, imem_wdata_o);
      end
      commit(0);
      n_checks++;
      if ({count_o, imem_addr_o, imem_we_o, in_ready_o} !== {9'd1, 8'h11, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL r_commit cnt=%0d addr=%h we=%0b rdy=%0b exp cnt=1 addr=11 we=0 rdy=1",
                  count_o, imem_addr_o, imem_we_o, in_ready_o);
      end
   endtask

   task automatic test_back_to_back();
      do_start(8'h10);
      set_fields(1, 1, 2, 0, 0, 0, 63);
      issue();
      n_checks++;
      if ({imem_we_o, in_ready_o, imem_addr_o, imem_wdata_o} !== {1'b1, 1'b0, 8'h10, 16'hFCA1}) begin
         n_fail++;
         $display("FAIL i_write we=%0b rdy=%0b addr=%h wdata=%h exp we=1 rdy=0 addr=10 wdata=fca1",
                  imem_we_o, in_ready_o, imem_addr_o, imem_wdata_o);
      end
      commit(0);
      set_fields(3, 0, 4, 7, 0, 2, 9);
      issue();
      n_checks++;
      if ({imem_we_o, in_ready_o, imem_addr_o, imem_wdata_o} !== {1'b1, 1'b0, 8'h11, 16'h9BC3}) begin
         n_fail++;
         $display("FAIL s_write we=%0b rdy=%0b addr=%h wdata=%h exp we=1 rdy=0 addr=11 wdata=9bc3",
                  imem_we_o, in_ready_o, imem_addr_o, imem_wdata_o);
      end
      commit(0);
      n_checks++;
      if ({count_o, imem_addr_o, imem_wdata_o} !== {9'd2, 8'h12, 16'h9BC3}) begin
         n_fail++;
         $display("FAIL b2b_commit cnt=%0d addr=%h wdata=%h exp cnt=2 addr=12 wdata=9bc3 held",
                  count_o, imem_addr_o, imem_wdata_o);
      end
   endtask

   task automatic test_illegal();
      int ops[3]  = '{6, 0, 2};
      int f4s[3]  = '{0, 4, 0};
      int rs2s[3] = '{0, 6, 0};
      int imms[3] = '{0, 0, 16};
      int codes[3] = '{1, 2, 3};
      for (int k = 0; k < 3; k++) begin
         set_fields(ops[k], 1, 2, rs2s[k], f4s[k], 1, imms[k]);
         issue();
         n_checks++;
         if ({err_o, err_code_o, imem_we_o, in_ready_o, count_o} !==
             {1'b1, 2'(codes[k]), 1'b0, 1'b1, 9'(m_count)}) begin
            n_fail++;
            $display("FAIL illegal_%0d err=%0b code=%0d we=%0b rdy=%0b cnt=%0d exp err=1 code=%0d we=0 rdy=1 cnt=%0d",
                     k, err_o, err_code_o, imem_we_o, in_ready_o, count_o, codes[k], m_count);
         end
         tick();
         n_checks++;
         if ({err_o, err_code_o, imem_we_o, count_o} !== {1'b0, 2'(codes[k]), 1'b0, 9'(m_count)}) begin
            n_fail++;
            $display("FAIL illegal_hold_%0d err=%0b code=%0d we=%0b cnt=%0d exp err=0 code=%0d we=0 cnt=%0d",
                     k, err_o, err_code_o, imem_we_o, count_o, codes[k], m_count);
         end
      end
      do_start(8'h20);
      n_checks++;
      if (err_code_o !== 2'b00) begin
         n_fail++;
         $display("FAIL err_clear_on_start code=%0d exp 0", err_code_o);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_w;
      exp_w = model_word(2, 3, 1, 0, 0, 1, 12);
      set_fields(2, 3, 1, 0, 0, 1, 12);
      issue();
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if ({imem_we_o, in_ready_o, imem_addr_o, imem_wdata_o} !== {1'b1, 1'b0, 8'(m_addr), exp_w}) begin
            n_fail++;
            $display("FAIL bp_stable_%0d we=%0b rdy=%0b addr=%h wdata=%h exp we=1 rdy=0 addr=%h wdata=%h",
                     c, imem_we_o, in_ready_o, imem_addr_o, imem_wdata_o, 8'(m_addr), exp_w);
         end
         // start_i is ignored while a write is pending
         start_i = (c == 1);
         base_addr_i = 8'hAA;
         tick();
         start_i = 1'b0;
      end
      commit(0);
      n_checks++;
      if ({imem_we_o, count_o, imem_addr_o} !== {1'b0, 9'(m_count), 8'(m_addr)}) begin
         n_fail++;
         $display("FAIL bp_commit we=%0b cnt=%0d addr=%h exp we=0 cnt=%0d addr=%h",
                  imem_we_o, count_o, imem_addr_o, m_count, 8'(m_addr));
      end
   endtask

   task automatic test_random();
      int op, rd, rs1, rs2, f4, f2, imm, e;
      logic [15:0] exp_w;
      do_start(8'($urandom_range(0, 255)));
      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 7); rd = $urandom_range(0, 7); rs1 = $urandom_range(0, 7);
         rs2 = $urandom_range(0, 7); f4 = $urandom_range(0, 15); f2 = $urandom_range(0, 3);
         imm = $urandom_range(0, 63);
         e = model_err(op, rs2, f4, imm);
         exp_w = model_word(op, rd, rs1, rs2, f4, f2, imm);
         set_fields(op, rd, rs1, rs2, f4, f2, imm);
         issue();
         n_checks++;
         if (e != 0) begin
            if ({err_o, err_code_o, imem_we_o, in_ready_o} !== {1'b1, 2'(e), 1'b0, 1'b1}) begin
               n_fail++;
               $display("FAIL rand_err_%0d op=%0d err=%0b code=%0d we=%0b rdy=%0b exp err=1 code=%0d we=0 rdy=1",
                        it, op, err_o, err_code_o, imem_we_o, in_ready_o, e);
            end
         end else begin
            if ({err_o, imem_we_o, imem_addr_o, imem_wdata_o} !== {1'b0, 1'b1, 8'(m_addr), exp_w}) begin
               n_fail++;
               $display("FAIL rand_write_%0d op=%0d err=%0b we=%0b addr=%h wdata=%h exp err=0 we=1 addr=%h wdata=%h",
                        it, op, err_o, imem_we_o, imem_addr_o, imem_wdata_o, 8'(m_addr), exp_w);
            end
            commit($urandom_range(0, 2));
         end
      end
      n_checks++;
      if ({count_o, imem_addr_o} !== {9'(m_count), 8'(m_addr)}) begin
         n_fail++;
         $display("FAIL rand_final cnt=%0d addr=%h exp cnt=%0d addr=%h",
                  count_o, imem_addr_o, m_count, 8'(m_addr));
      end
      // start wins over a same-cycle handshake; the fields are dropped
      set_fields(7, 0, 0, 0, 0, 0, 0);
      start_i = 1'b1; base_addr_i = 8'h33; in_valid_i = 1'b1;
      tick();
      start_i = 1'b0; in_valid_i = 1'b0;
      n_checks++;
      if ({err_o, err_code_o, imem_we_o, in_ready_o, count_o, imem_addr_o} !==
          {1'b0, 2'b00, 1'b0, 1'b1, 9'd0, 8'h33}) begin
         n_fail++;
         $display("FAIL start_wins err=%0b code=%0d we=%0b rdy=%0b cnt=%0d addr=%h exp 0 0 0 1 0 33",
                  err_o, err_code_o, imem_we_o, in_ready_o, count_o, imem_addr_o);
      end
   endtask

   task automatic test_full();
      int exp_a[4] = '{254, 255, 0, 1};
      do_reset();
      do_start(8'hFE);
      for (int k = 0; k < 4; k++) begin
         set_fields(1, k, k + 1, 0, 0, 0, k * 7);
         issue();
         n_checks++;
         if ({we4, addr4, wdata4} !== {1'b1, 8'(exp_a[k]), model_word(1, k, k + 1, 0, 0, 0, k * 7)}) begin
            n_fail++;
            $display("FAIL full_write_%0d we=%0b addr=%h wdata=%h exp we=1 addr=%h",
                     k, we4, addr4, wdata4, 8'(exp_a[k]));
         end
         commit(0);
      end
      n_checks++;
      if ({full4, in_ready4, count4, addr4} !== {1'b1, 1'b0, 9'd4, 8'h02}) begin
         n_fail++;
         $display("FAIL full_state full=%0b rdy=%0b cnt=%0d addr=%h exp full=1 rdy=0 cnt=4 addr=02",
                  full4, in_ready4, count4, addr4);
      end
      set_fields(7, 0, 0, 0, 0, 0, 0);
      issue();
      n_checks++;
      if ({we4, err4, full4} !== {1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL full_ignores we=%0b err=%0b full=%0b exp we=0 err=0 full=1", we4, err4, full4);
      end
      do_start(8'h40);
      n_checks++;
      if ({full4, in_ready4, count4, addr4} !== {1'b0, 1'b1, 9'd0, 8'h40}) begin
         n_fail++;
         $display("FAIL full_restart full=%0b rdy=%0b cnt=%0d addr=%h exp full=0 rdy=1 cnt=0 addr=40",
                  full4, in_ready4, count4, addr4);
      end
   endtask

   task automatic test_rst_mid_write();
      do_reset();
      do_start(8'h80);
      set_fields(0, 7, 7, 7, 15, 0, 0);
      issue();
      n_checks++;
      if (imem_we_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_write we=%0b exp 1", imem_we_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, count_o, full_o, err_o, err_code_o}
          !== {1'b0, 1'b0, 8'h00, 16'h0000, 9'd0, 1'b0, 1'b0, 2'b00}) begin
         n_fail++;
         $display("FAIL rst_mid_write rdy=%0b we=%0b addr=%h wdata=%h cnt=%0d full=%0b err=%0b code=%0d exp all zero",
                  in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, count_o, full_o, err_o, err_code_o);
      end
      tick();
      n_checks++;
      if ({in_ready_o, imem_we_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_idle rdy=%0b we=%0b exp 0 0", in_ready_o, imem_we_o);
      end
   endtask

   initial begin
      test_reset();
      test_directed_r();
      test_back_to_back();
      test_illegal();
      test_backpressure();
      test_random();
      test_full();
      test_rst_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Encoder counterpart of the 16-bit instruction decoder. It accepts instruction fields over a valid/ready handshake and checks them against the R/I/L/S formats. Each legal instruction is packed into a 16-bit word and written sequentially into instruction memory from a programmable base address. It is used by the boot/test loader to fill program memory; illegal field combinations are rejected and reported.

Parameters:
ADDR_W, 8, instruction-memory word address width
DEPTH, 256, maximum instructions per load session; legal range 1..2**ADDR_W

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
start_i  in  1  begin session: load base address, clear count and error state
base_addr_i  in  ADDR_W  first write address, sampled when start_i is accepted
in_valid_i  in  1  instruction fields valid
in_ready_o  out  1  encoder can accept fields
op_i  in  3  opcode
rd_i  in  3  destination register
rs1_i  in  3  source register 1
rs2_i  in  3  source register 2
func4_i  in  4  R-type function field
func2_i  in  2  L/S-type function field
imm_i  in  6  immediate
imem_we_o  out  1  memory write request
imem_addr_o  out  ADDR_W  write address
imem_wdata_o  out  16  encoded instruction
imem_ready_i  in  1  memory accepts write this cycle
count_o  out  ADDR_W+1  instructions written this session
full_o  out  1  count_o == DEPTH
err_o  out  1  one-cycle pulse on rejected instruction
err_code_o  out  2  last error: 00 none, 01 bad op, 10 R overlap, 11 L/S imm range

Behaviour:
- Reset: state IDLE; in_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, count_o=0, full_o=0, err_o=0, err_code_o=00.
- States: IDLE, ACCEPT, WRITE, FULL. in_ready_o=1 only in ACCEPT; imem_we_o=1 only in WRITE.
- start_i honoured in IDLE, ACCEPT and FULL. Next cycle: state ACCEPT, imem_addr_o=base_addr_i, count_o=0, full_o=0, err_code_o=00.
- start_i is ignored in WRITE; the pending write completes first.
- start_i in the same cycle as an ACCEPT handshake: start wins and the fields are dropped.
- Encoding, with bit 3 always 0 and fields unused by a format forced to 0:
  - R (000): [15:12]=func4, [11:10]=rs2[1:0], [9:7]=rd, [6:4]=rs1. Legal only if func4_i[0]==rs2_i[2], because the two fields share bit 12.
  - I (001): [15:10]=imm, [9:7]=rd, [6:4]=rs1.
  - L (010): [15:12]=imm[3:0], [11:10]=func2, [9:7]=rd, [6:4]=rs1. Legal only if imm_i[5:4]==0.
  - S (011): same as L, with rs2 in [9:7]. Same legality rule.
- Error priority: op>=100 gives 01; else R-type overlap conflict gives 10; else L/S imm range gives 11.
- Handshake in ACCEPT with illegal fields:
  - err_o pulses high the next cycle; err_code_o updates and holds until start_i or rst.
  - No write occurs, count_o is unchanged, and the state stays ACCEPT.
- Handshake in ACCEPT with legal fields:
  - The next cycle imem_wdata_o holds the encoded word, the state is WRITE and imem_we_o=1.
  - Latency is 1 cycle from accept to write request. Throughput is at most 1 instruction per 2 cycles.
- WRITE:
  - imem_we_o, imem_addr_o and imem_wdata_o stay stable until imem_ready_i=1.
  - On that cycle: imem_addr_o increments modulo 2**ADDR_W, wrapping with no error, and count_o increments.
  - Next state is FULL if the new count equals DEPTH, else ACCEPT.
- FULL: full_o=1 and in_ready_o=0 until start_i or rst.
- imem_wdata_o keeps its last value outside WRITE.
- rst mid-WRITE: the write is abandoned and all outputs return to reset values the next cycle.

Test Plan:
- rst, start_i with base=0x10; R op=000 rs1=3 rd=5 rs2=6 func4=0101 -> one cycle later imem_we_o=1, addr=0x10, wdata=0x5AB0; count_o=1 after imem_ready_i.
- I op=001 rs1=2 rd=1 imm=0x3F, then S op=011 rs1=4 rs2=7 func2=2 imm=0x9 back-to-back -> wdata 0xFCA1 at 0x10, then 0x9BC3 at 0x11; in_ready_o low during each WRITE.
- Illegal inputs:
  - op=110 -> err_o pulse, err_code_o=01.
  - R func4=0100 with rs2=6 -> err_code_o=10.
  - L imm=0x10 -> err_code_o=11.
  - For all three: no imem_we_o and count_o unchanged.
- Backpressure: imem_ready_i low 3 cycles during WRITE -> we/addr/wdata stable and in_ready_o=0; write commits on cycle 4.
- DEPTH=4, base=0xFE, 4 legal instructions -> addresses 0xFE, 0xFF, 0x00, 0x01; then full_o=1, in_ready_o=0; start_i clears count_o to 0 and returns to ACCEPT.
- rst asserted while imem_we_o=1 and imem_ready_i=0 -> next cycle all outputs at reset values, state IDLE.
